// File: rtl/text_term_writer.sv
// Character terminal writer: turns a host ASCII byte stream into video RAM writes,
// tracking a cursor and blanking lines or the whole screen on newline / form feed.
module text_term_writer #(
   parameter int unsigned COLS  = 80,
   parameter int unsigned ROWS  = 30,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [7:0]  i_dat,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [12:0] o_mem_addr,
   output logic [7:0]  o_mem_dat,
   output logic        o_mem_we,
   input  logic        i_mem_busy,
   output logic [6:0]  o_cur_col,
   output logic [4:0]  o_cur_row
);

   localparam logic [12:0] SCR_LAST = 13'(COLS * ROWS - 1);
   localparam logic [12:0] COLS_W   = 13'(COLS);
   localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
   localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);

   typedef enum logic [1:0] {StIdle, StPut, StClrLine, StClrScr} state_e;

   state_e      state_q, state_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [12:0] addr_q, addr_d;
   logic [12:0] last_q, last_d;
   logic [7:0]  dat_q, dat_d;
   logic        ready_q, ready_d;

   logic [4:0]  row_inc;
   logic [12:0] line_base;
   logic        accept;
   logic        grant;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         last_q  <= '0;
         dat_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         dat_q   <= dat_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      addr_d    = addr_q;
      last_d    = last_q;
      dat_d     = dat_q;
      row_inc   = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
      line_base = 13'(row_inc) * COLS_W;
      accept    = i_valid && ready_q;
      grant     = (state_q != StIdle) && !i_mem_busy;

      case (state_q)
         StIdle: begin
            if (accept) begin
               if (i_dat >= 8'h20 && i_dat <= 8'h7e) begin
                  addr_d  = 13'(row_q) * COLS_W + 13'(col_q);
                  dat_d   = i_dat;
                  state_d = StPut;
               end else begin
                  case (i_dat)
                     8'h0d: col_d = '0;
                     8'h0a: begin
                        row_d   = row_inc;
                        addr_d  = line_base;
                        last_d  = line_base + COLS_W - 13'd1;
                        dat_d   = BLANK;
                        state_d = StClrLine;
                     end
                     8'h08: if (col_q != '0) col_d = col_q - 7'd1;
                     8'h0c: begin
                        col_d   = '0;
                        row_d   = '0;
                        addr_d  = '0;
                        last_d  = SCR_LAST;
                        dat_d   = BLANK;
                        state_d = StClrScr;
                     end
                     default: ;
                  endcase
               end
            end
         end
         StPut: begin
            if (grant) begin
               if (col_q == COL_LAST) begin
                  // Wrap off the right edge: newline and blank the new row.
                  col_d   = '0;
                  row_d   = row_inc;
                  addr_d  = line_base;
                  last_d  = line_base + COLS_W - 13'd1;
                  dat_d   = BLANK;
                  state_d = StClrLine;
               end else begin
                  col_d   = col_q + 7'd1;
                  state_d = StIdle;
               end
            end
         end
         StClrLine, StClrScr: begin
            if (grant) begin
               if (addr_q == last_q) state_d = StIdle;
               else                  addr_d  = addr_q + 13'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      ready_d = (state_d == StIdle);
   end

   assign o_ready    = ready_q;
   assign o_mem_we   = (state_q != StIdle);
   assign o_mem_addr = addr_q;
   assign o_mem_dat  = dat_q;
   assign o_cur_col  = col_q;
   assign o_cur_row  = row_q;

endmodule

// File: doc/text_term_writer.md
TEXT_TERM_WRITER -- requirements
Module: text_term_writer

Interface
REQ-001 The module SHALL have parameter COLS, default 80, meaning characters per row.
REQ-002 The module SHALL have parameter ROWS, default 30, meaning rows per screen.
REQ-003 The module SHALL have parameter BLANK, default 8'h20, meaning the fill byte for clears.
REQ-004 The module SHALL have one clock and an asynchronous, active-low reset: i_clk, i_reset_n.
REQ-005 i_clk  input  1  sole clock; all state on rising edge.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 i_dat  input  8  ASCII byte from host.
REQ-008 i_valid  input  1  i_dat valid.
REQ-009 o_ready  output  1  byte accepted when i_valid and o_ready are high on the same edge.
REQ-010 o_mem_addr  output  13  video RAM byte address = row*COLS + col.
REQ-011 o_mem_dat  output  8  video RAM write data.
REQ-012 o_mem_we  output  1  write request, held until granted.
REQ-013 i_mem_busy  input  1  display reader owns the RAM this cycle; a write completes only on an edge where o_mem_we=1 and i_mem_busy=0.
REQ-014 o_cur_col  output  7  cursor column, 0..COLS-1.
REQ-015 o_cur_row  output  5  cursor row, 0..ROWS-1.

Function
REQ-016 States: IDLE, PUT, CLRLINE, CLRSCR; o_ready=1 only in IDLE.
REQ-017 IDLE, byte accepted: 0x20..0x7E -> PUT, with o_mem_addr/o_mem_dat latched to the cursor address and the byte.
REQ-018 IDLE, 0x0D (CR): col<=0, stay IDLE, no RAM write.
REQ-019 IDLE, 0x0A (LF): newline -- row<=row+1, or 0 if row=ROWS-1; col unchanged; -> CLRLINE on the new row.
REQ-020 IDLE, 0x08 (BS): col<=col-1 if col>0, else unchanged; no RAM write.
REQ-021 IDLE, 0x0C (FF): -> CLRSCR; cursor <= (0,0) on entry.
REQ-022 IDLE, any other byte: consumed and ignored; no state change.
REQ-023 PUT: o_mem_we=1 until granted.
REQ-024 PUT, grant edge: col<=col+1 and -> IDLE; if col=COLS-1, col<=0, newline per REQ-019, and -> CLRLINE.
REQ-025 CLRLINE: writes BLANK to row*COLS+k, k=0..COLS-1, in ascending order; one write per granted cycle; after the last grant -> IDLE.
REQ-026 CLRSCR: writes BLANK to addresses 0..COLS*ROWS-1 in ascending order; after the last grant -> IDLE.
REQ-027 While i_mem_busy=1, o_mem_addr, o_mem_dat and o_mem_we SHALL be held stable; the clear counters do not advance.
REQ-028 o_mem_we SHALL be 0 in IDLE; no address SHALL be written twice per operation, none skipped.
REQ-029 Address arithmetic SHALL be 13-bit unsigned; COLS*ROWS SHALL be <= 8192.
REQ-030 A single accepted byte SHALL cause at most one PUT followed by at most one CLRLINE.

Reset
REQ-031 On i_reset_n=0, asynchronously: state<=IDLE, cursor<=(0,0), o_mem_we<=0, o_mem_addr<=0, o_mem_dat<=0, o_ready<=0.
REQ-032 o_ready SHALL rise on the first clock edge after reset deassertion.
REQ-033 Reset mid-PUT/CLRLINE/CLRSCR SHALL abort the operation with no further writes; the screen is not cleared on reset.

Verification
REQ-034 'A' at (0,0), i_mem_busy=0 -> one write: addr 0, dat 0x41; cursor (1,0); o_ready back in 2 cycles.
REQ-035 'B' at (79,5) -> write addr 479; cursor (0,6); 80 writes of 0x20 to addrs 480..559; then IDLE.
REQ-036 LF at row 29, col 10 -> cursor (10,0); addrs 0..79 blanked.
REQ-037 FF with i_mem_busy toggling 1,0 each cycle -> exactly 2400 writes to addrs 0..2399, each addr once; o_ready=0 throughout; cursor (0,0).
REQ-038 CR, BS at col 0, and byte 0x07 -> no writes; BS at col 5 -> col 4.
REQ-039 Reset asserted mid-CLRSCR at addr 1000 -> o_mem_we=0 immediately; cursor (0,0); no writes after deassertion until a new byte is accepted.
